// File: rtl/leading_one_normalizer.sv
// Iterative left-normalizer: shifts one bit per clock until the MSB is set or the count saturates.
// Optional LON_ZERO_DETECT_EN finishes a zero operand immediately instead of shifting it out.
module leading_one_normalizer #(
    parameter int WIDTH       = 32,
    parameter int COUNT_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WIDTH-1:0]       in,
    output logic [WIDTH-1:0]       out,
    output logic [COUNT_WIDTH-1:0] shift_count,
    output logic                   done,
    output logic                   busy,
    output logic                   sat
);

    localparam logic [COUNT_WIDTH-1:0] MAX_SHIFT = '1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out         <= '0;
            shift_count <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            sat         <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
`ifdef LON_ZERO_DETECT_EN
                        if (in == '0) begin
                            state       <= DONE;
                            out         <= '0;
                            shift_count <= MAX_SHIFT;
                            done        <= 1'b1;
                            busy        <= 1'b0;
                            sat         <= 1'b1;
                        end else begin
                            state       <= SHIFT;
                            out         <= in;
                            shift_count <= '0;
                            done        <= 1'b0;
                            busy        <= 1'b1;
                            sat         <= 1'b0;
                        end
`else
                        state       <= SHIFT;
                        out         <= in;
                        shift_count <= '0;
                        done        <= 1'b0;
                        busy        <= 1'b1;
                        sat         <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    // out is not modified on the finishing edge, so sat sees the final MSB
                    if (out[WIDTH-1] || shift_count == MAX_SHIFT) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        sat   <= ~out[WIDTH-1];
                    end else begin
                        out         <= {out[WIDTH-2:0], 1'b0};
                        shift_count <= shift_count + COUNT_WIDTH'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    sat   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_leading_one_normalizer.sv
// Self-checking bench for leading_one_normalizer: directed table, corner sequences, random vs model.
module tb_leading_one_normalizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] in;
    logic [31:0] out;
    logic [3:0]  shift_count;
    logic        done;
    logic        busy;
    logic        sat;

    int total = 0;
    int bad   = 0;

    leading_one_normalizer #(.WIDTH(32), .COUNT_WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in          (in),
        .out         (out),
        .shift_count (shift_count),
        .done        (done),
        .busy        (busy),
        .sat         (sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] vin;
        logic [31:0] eout;
        int          ecnt;
        logic        esat;
        int          elat;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one operation and wait (bounded) for done; lat = edges after E0.
    task automatic run(input logic [31:0] v, output int lat, output int bcyc);
        start = 1'b1;
        in    = v;
        tick();
        start = 1'b0;
        in    = $urandom;
        lat   = 0;
        bcyc  = 0;
        while (!done && lat < 40) begin
            if (busy) bcyc++;
            tick();
            lat++;
        end
    endtask

    // Reference: count leading zeros, clamp to the shift budget.
    function automatic void model(input logic [31:0] v, output logic [31:0] o,
                                  output int n, output logic s, output int lat);
        int k = 0;
        while (k < 32 && v[31-k] == 1'b0) k++;
        n   = (k < 15) ? k : 15;
        o   = v << n;
        s   = ~o[31];
        lat = n + 1;
`ifdef LON_ZERO_DETECT_EN
        if (v == 0) lat = 0;
`endif
    endfunction

    initial begin
        int lat;
        int bcyc;
        logic [31:0] mo;
        int mn;
        logic ms;
        int ml;
        logic seen;

        vecs[0] = '{32'h3C3C3C3C, 32'hF0F0F0F0, 2, 1'b0, 3};
        vecs[1] = '{32'h15555555, 32'hAAAAAAA8, 3, 1'b0, 4};
        vecs[2] = '{32'h80000001, 32'h80000001, 0, 1'b0, 1};
        vecs[3] = '{32'h00001234, 32'h091A0000, 15, 1'b1, 16};
        vecs[4] = '{32'h00010000, 32'h80000000, 15, 1'b0, 16};
        vecs[5] = '{32'h00008000, 32'h40000000, 15, 1'b1, 16};
        vecs[6] = '{32'h40000000, 32'h80000000, 1, 1'b0, 2};
`ifdef LON_ZERO_DETECT_EN
        vecs[7] = '{32'h00000000, 32'h00000000, 15, 1'b1, 0};
`else
        vecs[7] = '{32'h00000000, 32'h00000000, 15, 1'b1, 16};
`endif

        rst   = 1'b1;
        start = 1'b0;
        in    = '0;
        tick();
        tick();
        check("reset_out", 64'(out), 64'h0);
        check("reset_cnt", 64'(shift_count), 64'h0);
        check("reset_flags", {61'h0, done, busy, sat}, 64'h0);
        rst = 1'b0;
        tick();
        check("idle_hold", {61'h0, done, busy, sat}, 64'h0);

        foreach (vecs[i]) begin
            run(vecs[i].vin, lat, bcyc);
            check($sformatf("tbl%0d_lat", i), 64'(lat), 64'(vecs[i].elat));
            check($sformatf("tbl%0d_out", i), 64'(out), 64'(vecs[i].eout));
            check($sformatf("tbl%0d_cnt", i), 64'(shift_count), 64'(vecs[i].ecnt));
            check($sformatf("tbl%0d_sat", i), 64'(sat), 64'(vecs[i].esat));
            check($sformatf("tbl%0d_busy", i), 64'(bcyc),
                  64'((vecs[i].elat > 0) ? vecs[i].elat : 0));
        end

        // Back-to-back: start in the done cycle
        run(32'h15555555, lat, bcyc);
        check("b2b_first_done", 64'(done), 64'h1);
        check("b2b_first_out", 64'(out), 64'hAAAAAAA8);
        run(32'h80000001, lat, bcyc);
        check("b2b_lat", 64'(lat), 64'h1);
        check("b2b_out", 64'(out), 64'h80000001);
        check("b2b_cnt", 64'(shift_count), 64'h0);

        // start ignored while busy
        start = 1'b1;
        in    = 32'h00001234;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        in    = 32'hFFFFFFFF;
        tick();
        start = 1'b0;
        lat   = 3;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        check("ign_lat", 64'(lat), 64'd16);
        check("ign_out", 64'(out), 64'h091A0000);
        check("ign_cnt", 64'(shift_count), 64'd15);

        // Reset mid-operation
        start = 1'b1;
        in    = 32'h00001234;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_out", 64'(out), 64'h0);
        check("abort_flags", {60'h0, shift_count != 0, done, busy, sat}, 64'h0);
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (done || busy) seen = 1'b1;
        end
        check("abort_no_done", 64'(seen), 64'h0);
        run(32'h40000000, lat, bcyc);
        check("after_abort_lat", 64'(lat), 64'd2);
        check("after_abort_out", 64'(out), 64'h80000000);
        check("after_abort_cnt", 64'(shift_count), 64'd1);

        // rst and start on the same edge
        rst   = 1'b1;
        start = 1'b1;
        in    = 32'h00000001;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        seen  = 1'b0;
        repeat (5) begin
            if (done || busy) seen = 1'b1;
            tick();
        end
        check("rst_start_idle", 64'(seen), 64'h0);

        // Randomized against the model
        for (int r = 0; r < 200; r++) begin
            logic [31:0] v;
            v = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 19) == 0) v = '0;
            model(v, mo, mn, ms, ml);
            run(v, lat, bcyc);
            check($sformatf("rnd%0d_lat", r), 64'(lat), 64'(ml));
            check($sformatf("rnd%0d_res", r), {27'h0, ms, shift_count, out},
                  {27'h0, ms, 4'(mn), mo});
            check($sformatf("rnd%0d_sat", r), 64'(sat), 64'(ms));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
